ahb_lite_master: RTL
====================

// Module: ahb_lite_master
// PURPOSE
//  AHB-Lite bus master: turns single-command requests from a local client into AHB-Lite
//  address/data-phase transfers (SINGLE, or INCR4 when compiled in). Drives the slave-side
//  HSEL/HADDR/... bus and consumes HREADY/HRESP/HRDATA. It is the initiator counterpart
//  to the memory slave and is the bench/system driver for it.
// PARAMETERS
//  MAX_HSIZE     2        largest legal HSIZE encoding (2 = word on `BUS_WIDTH=32)
//  HPROT_DEFAULT 4'b0011  constant driven on HPROT (data access, privileged)
// PORTS
//  HCLK       in   1          bus clock; all logic on rising edge
//  HRESETn    in   1          reset, synchronous, active-low
//  cmd_valid  in   1          client command request
//  cmd_ready  out  1          master can accept a command (high only in IDLE)
//  cmd_write  in   1          1 = write, 0 = read
//  cmd_addr   in   `BUS_WIDTH start byte address
//  cmd_size   in   3          HSIZE encoding
//  cmd_burst  in   1          1 = INCR4 (only with AHB_LITE_MASTER_BURST_EN)
//  cmd_wdata  in   `BUS_WIDTH write data; sampled when wd_req=1
//  wd_req     out  1          pulse: current write beat's data sampled this cycle
//  HADDR      out  `BUS_WIDTH  HWRITE out 1  HSIZE out 3  HBURST out 3  HPROT out 4
//  HTRANS     out  2           HMASTLOCK out 1 (tied 0)  HWDATA out `BUS_WIDTH
//  HREADY     in   1          transfer-complete / wait-state input
//  HRESP      in   1          `OKAY / `ERROR
//  HRDATA     in   `BUS_WIDTH read data
//  rd_valid   out  1          pulse: rd_data holds one read beat
//  rd_data    out  `BUS_WIDTH registered HRDATA of completed read beat
//  rd_last    out  1          with rd_valid: final beat of command
//  rsp_valid  out  1          pulse: command finished
//  rsp_err    out  1          with rsp_valid: 1 = error/rejected
// BEHAVIOUR
//  Reset (HRESETn=0 at edge): HTRANS=IDLE, HADDR/HWDATA/HSIZE/HBURST/HWRITE=0,
//   HPROT=HPROT_DEFAULT, HMASTLOCK=0, rd_valid/rd_last/rsp_valid/rsp_err/wd_req=0,
//   rd_data=0, FSM=IDLE. Reset mid-transfer: bus back to IDLE next edge, no rsp emitted.
//  FSM: IDLE -> ADDR -> DATA -> (ADDR|DATA for further beats) -> IDLE; ERR1 -> ERR2 -> IDLE.
//  IDLE: cmd_ready=1. Accept on cmd_valid&cmd_ready (cycle N). Checks at accept:
//   cmd_size>MAX_HSIZE, cmd_addr not aligned to 1<<cmd_size, or INCR4 crossing a 1KB
//   boundary -> no bus activity; rsp_valid=1,rsp_err=1 at N+1; back to IDLE.
//  ADDR (from N+1): HTRANS=NONSEQ (beat 0) / SEQ (beats 1-3), HADDR/HSIZE/HWRITE/HBURST
//   held stable until sampled with HREADY=1. Beat address = start + k*(1<<HSIZE).
//  Write data: wd_req=1 in the cycle a beat's address phase completes; cmd_wdata that
//   cycle is registered into HWDATA and held through that beat's data phase.
//  DATA: beat completes on HREADY=1 & HRESP=`OKAY. Next beat's address phase overlaps it
//   (pipelined); after last beat HTRANS=IDLE. Reads: rd_valid=1 next cycle, rd_data=HRDATA.
//  Completion: rsp_valid=1,rsp_err=0 one cycle after last data phase completes (same
//   cycle as last rd_valid/rd_last). Single write, zero waits: accept N, NONSEQ N+1,
//   data N+2, rsp_valid N+3.
//  Error: HRESP=`ERROR & HREADY=0 (ERR1) -> HTRANS=IDLE next cycle, pending SEQ cancelled;
//   HRESP=`ERROR & HREADY=1 (ERR2) -> rsp_valid=1,rsp_err=1 next cycle; remaining beats
//   dropped, no rd_valid for the errored beat. HREADY low any length = wait, all held.
// CONFIGURATION
//  AHB_LITE_MASTER_BURST_EN defined: cmd_burst=1 issues INCR4 (HBURST=3'b011, 4 beats,
//   NONSEQ,SEQ,SEQ,SEQ). Undefined: cmd_burst ignored, HBURST=3'b000 always, HTRANS never
//   SEQ, burst/1KB check removed, beat counter logic not built.
// TESTING
//  Single write addr 0x10 size 2 data 0xDEADBEEF, HREADY=1 -> NONSEQ at N+1, HWDATA at N+2, rsp ok N+3.
//  Single read 0x10 with 2 wait states -> HADDR held 3 cycles; rd_data=0xDEADBEEF, rd_last=1, rsp ok.
//  Unaligned addr 0x02 size 2 -> HTRANS stays IDLE; rsp_valid,rsp_err=1 at N+1.
//  Slave 2-cycle ERROR on read 0x3FC -> HTRANS IDLE in ERR2, rsp_err=1, no rd_valid.
//  (BURST_EN) INCR4 read 0x100 size 2 -> HADDR 0x100,104,108,10C; 4 rd_valid, rd_last on 4th.
//  (BURST_EN) INCR4 at 0x3F8 size 2 -> rejected, rsp_err=1, no bus cycle; reset mid-burst -> IDLE, no rsp.

Source files
------------

// File: rtl/ahb_lite_master.sv
// AHB-Lite bus master: turns single client commands into SINGLE (or INCR4) bus transfers.
// Optional INCR4 support is compiled in with `define AHB_LITE_MASTER_BURST_EN.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef OKAY
`define OKAY 1'b0
`endif
`ifndef ERROR
`define ERROR 1'b1
`endif

module ahb_lite_master #(
   parameter int unsigned MAX_HSIZE     = 2,
   parameter logic [3:0]  HPROT_DEFAULT = 4'b0011
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [`BUS_WIDTH-1:0] cmd_addr,
   input  logic [2:0]            cmd_size,
   input  logic                  cmd_burst,
   input  logic [`BUS_WIDTH-1:0] cmd_wdata,
   output logic                  wd_req,
   output logic [`BUS_WIDTH-1:0] HADDR,
   output logic                  HWRITE,
   output logic [2:0]            HSIZE,
   output logic [2:0]            HBURST,
   output logic [3:0]            HPROT,
   output logic [1:0]            HTRANS,
   output logic                  HMASTLOCK,
   output logic [`BUS_WIDTH-1:0] HWDATA,
   input  logic                  HREADY,
   input  logic                  HRESP,
   input  logic [`BUS_WIDTH-1:0] HRDATA,
   output logic                  rd_valid,
   output logic [`BUS_WIDTH-1:0] rd_data,
   output logic                  rd_last,
   output logic                  rsp_valid,
   output logic                  rsp_err
);
   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_NONSEQ = 2'b10;
   localparam logic [1:0] TR_SEQ    = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_ERR} state_t;
   state_t state;

   logic                  dlast;
   logic                  addr_last;
   logic                  addr_done;
   logic                  size_bad, align_bad, bound_bad, reject;
   logic [`BUS_WIDTH-1:0] incr, align_mask;

   assign incr       = `BUS_WIDTH'(1) << HSIZE;
   assign align_mask = (`BUS_WIDTH'(1) << cmd_size) - `BUS_WIDTH'(1);
   assign size_bad   = cmd_size > 3'(MAX_HSIZE);
   assign align_bad  = (cmd_addr & align_mask) != '0;

`ifdef AHB_LITE_MASTER_BURST_EN
   logic [1:0]  abeat;
   logic        is_burst;
   logic [11:0] burst_end;
   // An INCR4 may end exactly on the 1KB line but not past it.
   assign burst_end = {2'b00, cmd_addr[9:0]} + (12'd4 << cmd_size);
   assign bound_bad = cmd_burst && (burst_end > 12'h400);
   assign addr_last = !is_burst || (abeat == 2'd3);
`else
   logic unused_burst;
   assign unused_burst = cmd_burst;
   assign bound_bad    = 1'b0;
   assign addr_last    = 1'b1;
`endif

   assign reject    = size_bad | align_bad | bound_bad;
   assign cmd_ready = (state == S_IDLE);
   assign HPROT     = HPROT_DEFAULT;
   assign HMASTLOCK = 1'b0;

   // Address phase is taken when HREADY is high and the overlapped data phase (if any) is OKAY.
   assign addr_done = HTRANS[1] && HREADY &&
                      ((state == S_ADDR) || ((state == S_DATA) && (HRESP == `OKAY)));
   assign wd_req    = HWRITE && addr_done;

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state     <= S_IDLE;
         HTRANS    <= TR_IDLE;
         HADDR     <= '0;
         HWDATA    <= '0;
         HSIZE     <= '0;
         HBURST    <= '0;
         HWRITE    <= 1'b0;
         rd_valid  <= 1'b0;
         rd_last   <= 1'b0;
         rd_data   <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         dlast     <= 1'b0;
`ifdef AHB_LITE_MASTER_BURST_EN
         abeat     <= '0;
         is_burst  <= 1'b0;
`endif
      end else begin
         rd_valid  <= 1'b0;
         rd_last   <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;

         if (addr_done) begin
            if (HWRITE) HWDATA <= cmd_wdata;
            dlast <= addr_last;
            if (addr_last) begin
               HTRANS <= TR_IDLE;
            end else begin
               HTRANS <= TR_SEQ;
               HADDR  <= HADDR + incr;
`ifdef AHB_LITE_MASTER_BURST_EN
               abeat  <= abeat + 2'd1;
`endif
            end
         end

         case (state)
            S_IDLE: if (cmd_valid) begin
               if (reject) begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
               end else begin
                  HTRANS <= TR_NONSEQ;
                  HADDR  <= cmd_addr;
                  HSIZE  <= cmd_size;
                  HWRITE <= cmd_write;
`ifdef AHB_LITE_MASTER_BURST_EN
                  is_burst <= cmd_burst;
                  abeat    <= '0;
                  HBURST   <= cmd_burst ? 3'b011 : 3'b000;
`endif
                  state  <= S_ADDR;
               end
            end
            S_ADDR: if (HREADY) state <= S_DATA;
            S_DATA: begin
               if (HRESP == `ERROR) begin
                  // Any pipelined SEQ is withdrawn; remaining beats are dropped.
                  HTRANS <= TR_IDLE;
                  if (HREADY) begin
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     state     <= S_IDLE;
                  end else begin
                     state <= S_ERR;
                  end
               end else if (HREADY) begin
                  if (!HWRITE) begin
                     rd_valid <= 1'b1;
                     rd_data  <= HRDATA;
                     rd_last  <= dlast;
                  end
                  if (dlast) begin
                     rsp_valid <= 1'b1;
                     state     <= S_IDLE;
                  end
               end
            end
            S_ERR: if (HREADY) begin
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b1;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
